// File: rtl/xor_accum_pkg.sv
// xor_accum_pkg: mode and state encodings shared by the xor_accum block
package xor_accum_pkg;
  localparam logic MODE_PAIR  = 1'b0;
  localparam logic MODE_BLOCK = 1'b1;
  typedef enum logic {IDLE = 1'b0, ACCUM = 1'b1} state_t;
endpackage

// File: rtl/xor_accum_xor_n.sv
// xor_n: WIDTH-wide bitwise XOR array built from the 1-bit Xor cell
module Xor (
  input  logic i_a,
  input  logic i_b,
  output logic o_y
);
  assign o_y = i_a ^ i_b;
endmodule

module xor_n #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_y
);
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    Xor u_cell (.i_a(i_a[i]), .i_b(i_b[i]), .o_y(o_y[i]));
  end
endmodule

// File: rtl/xor_accum.sv
// xor_accum: registered pairwise XOR or running XOR checksum over fixed-length blocks
module xor_accum
  import xor_accum_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int BLOCK_LEN = 8,
  localparam int CNT_W = $clog2(BLOCK_LEN + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mode,
  input  logic             inValid,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  input  logic             flush,
  output logic [WIDTH-1:0] out,
  output logic             parity,
  output logic             outValid,
  output logic [CNT_W-1:0] count,
  output logic             busy
);
  state_t           r_state, w_state_n;
  logic [WIDTH-1:0] r_acc, w_acc_n, w_acc_in, w_word, w_emit, r_out;
  logic [CNT_W-1:0] r_count, w_cnt_n, w_cnt_in;
  logic             r_out_valid, w_done, w_open;
  xor_n #(.WIDTH(WIDTH)) u_xor (.i_a(inA), .i_b(inB), .o_y(w_word));
  // In IDLE, a word finishes immediately unless it opens a multi-word block
  always_comb begin
    w_acc_in  = inValid ? r_acc ^ w_word : r_acc;
    w_cnt_in  = r_count + CNT_W'(inValid);
    w_done    = (r_state == ACCUM)
              ? (flush || (inValid && w_cnt_in == CNT_W'(BLOCK_LEN)))
              : (inValid && (mode == MODE_PAIR || BLOCK_LEN == 1 || flush));
    w_open    = (r_state == IDLE) && inValid && !w_done;
    w_emit    = (r_state == ACCUM) ? w_acc_in : w_word;
    w_state_n = w_open ? ACCUM : w_done ? IDLE : r_state;
    w_acc_n   = w_done ? '0 : w_open ? w_word : (r_state == ACCUM) ? w_acc_in : r_acc;
    w_cnt_n   = w_done ? '0 : w_open ? CNT_W'(1) : (r_state == ACCUM) ? w_cnt_in : r_count;
  end
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else r_state <= w_state_n;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc       <= '0;
      r_count     <= '0;
      r_out       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_acc       <= w_acc_n;
      r_count     <= w_cnt_n;
      r_out_valid <= w_done;
      if (w_done) r_out <= w_emit;
    end
  end
  assign out      = r_out;
  assign parity   = ^r_out;
  assign outValid = r_out_valid;
  assign count    = r_count;
  assign busy     = (r_state == ACCUM);
endmodule
